// File: rtl/sram_arbiter_pkg.sv
// ============================================================================
// sram_arbiter_pkg : shared arbiter state type, SRAM timing defaults, read tag
// Revision: 1.0
// ============================================================================
`default_nettype none

package sram_arbiter_pkg;

   typedef enum logic [0:0] {
      ARB_READY = 1'b0,
      ARB_TURN  = 1'b1
   } arb_state_type;

   localparam int SRAM_READ_LATENCY = 2;
   localparam int ARB_MAX_WAIT      = 4;

   typedef struct packed {
      logic valid;
      logic port;
   } read_tag_t;

endpackage

`default_nettype wire

// File: rtl/sram_read_tag_pipe.sv
// ============================================================================
// sram_read_tag_pipe : shift register of {valid, port} read tags, sync clear
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_read_tag_pipe
   import sram_arbiter_pkg::*;
#(
   parameter int DEPTH = 3
) (
   input  logic      clk_i,
   input  logic      clr_i,
   input  read_tag_t tag_i,
   output read_tag_t tag_o
);

   read_tag_t stage_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            stage_q[i] <= '0;
         end
      end else begin
         stage_q[0] <= tag_i;
         for (int i = 1; i < DEPTH; i++) begin
            stage_q[i] <= stage_q[i-1];
         end
      end
   end

   assign tag_o = stage_q[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/sram_arbiter.sv
// ============================================================================
// sram_arbiter : two-port fixed-priority SRAM arbiter with starvation bound,
//                read->write turnaround bubble and tagged read return
// Revision: 1.0
// ============================================================================
`default_nettype none

module sram_arbiter
   import sram_arbiter_pkg::*;
#(
   parameter int READ_LATENCY = SRAM_READ_LATENCY,
   parameter int MAX_WAIT     = ARB_MAX_WAIT
) (
   input  logic        Clock_50,
   input  logic        Reset,
   input  logic        SRAM_ready,
   input  logic [1:0]  req,
   input  logic [1:0]  we_n,
   input  logic [17:0] addr0,
   input  logic [17:0] addr1,
   input  logic [15:0] wdata0,
   input  logic [15:0] wdata1,
   output logic [1:0]  gnt,
   output logic [1:0]  rvalid,
   output logic [15:0] rdata,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n,
   input  logic [15:0] SRAM_read_data
);

   arb_state_type state_q, state_d;
   logic [2:0]    starve_q, starve_d;
   logic          last_read_q;
   logic [17:0]   addr_q;
   logic [15:0]   wdata_q;
   logic          we_n_q;
   logic [1:0]    rvalid_q;
   logic [15:0]   rdata_q;

   logic          w_force1;
   logic          w_pick1;
   logic          w_cand;
   logic          w_cand_we_n;
   logic          w_turn;
   logic          w_accept;
   read_tag_t     w_tag_in;
   read_tag_t     w_tag_out;

   assign w_force1    = req[1] && (starve_q == 3'(MAX_WAIT));
   assign w_pick1     = req[1] && (!req[0] || w_force1);
   assign w_cand      = |req;
   assign w_cand_we_n = w_pick1 ? we_n[1] : we_n[0];
   // Only ARB_READY checks for the hazard, so the write is granted in ARB_TURN.
   assign w_turn      = (state_q == ARB_READY) && w_cand && !w_cand_we_n && last_read_q;

   always_comb begin
      gnt      = 2'b00;
      state_d  = state_q;
      starve_d = starve_q;

      if (SRAM_ready && !Reset && w_cand && !w_turn) begin
         gnt = w_pick1 ? 2'b10 : 2'b01;
      end

      case (state_q)
         ARB_READY: if (w_turn && SRAM_ready) state_d = ARB_TURN;
         ARB_TURN:  state_d = ARB_READY;
         default:   state_d = ARB_READY;
      endcase

      if (!req[1] || gnt[1]) begin
         starve_d = 3'd0;
      end else if (gnt[0]) begin
         starve_d = starve_q + 3'd1;
      end
   end

   assign w_accept       = |(req & gnt);
   assign w_tag_in.valid = w_accept && w_cand_we_n;
   assign w_tag_in.port  = w_pick1;

   sram_read_tag_pipe #(
      .DEPTH (READ_LATENCY + 1)
   ) u_tag_pipe (
      .clk_i (Clock_50),
      .clr_i (Reset),
      .tag_i (w_tag_in),
      .tag_o (w_tag_out)
   );

   always_ff @(posedge Clock_50) begin
      if (Reset) begin
         state_q     <= ARB_READY;
         starve_q    <= 3'd0;
         last_read_q <= 1'b0;
         addr_q      <= 18'd0;
         wdata_q     <= 16'd0;
         we_n_q      <= 1'b1;
         rvalid_q    <= 2'b00;
         rdata_q     <= 16'd0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         if (w_accept) begin
            addr_q      <= w_pick1 ? addr1 : addr0;
            wdata_q     <= w_pick1 ? wdata1 : wdata0;
            we_n_q      <= w_cand_we_n;
            last_read_q <= w_cand_we_n;
         end else begin
            we_n_q <= 1'b1;
         end
         rvalid_q <= w_tag_out.valid ? (w_tag_out.port ? 2'b10 : 2'b01) : 2'b00;
         if (w_tag_out.valid) begin
            rdata_q <= SRAM_read_data;
         end
      end
   end

   assign SRAM_address    = addr_q;
   assign SRAM_write_data = wdata_q;
   assign SRAM_we_n       = we_n_q;
   assign rvalid          = rvalid_q;
   assign rdata           = rdata_q;

endmodule

`default_nettype wire
